// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter with inhibit/RTS, odd parity and ack check
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] txData,
    input  logic       txStart,
    output logic       txBusy,
    output logic       txDone,
    output logic       txError,
    input  logic       ps2ClkIn,
    input  logic       ps2DataIn,
    output logic       ps2ClkOe,
    output logic       ps2DataOe
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, ERROR} state_t;

    state_t state, next;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic clk_prev, clk_s, data_s, fall, inh_done, timeout;
    logic [10:0] shift;
    logic [3:0] bit_cnt;
    logic [CW-1:0] cnt;

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign data_s   = data_sync[SYNC_STAGES-1];
    assign fall     = clk_prev & ~clk_s;
    assign inh_done = cnt == CW'(INHIBIT_CYCLES - 1);
    assign timeout  = cnt == CW'(TIMEOUT_CYCLES - 1);

    // synchronise the open-drain lines (idle high) and keep the previous clock for edge detect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2ClkIn};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2DataIn};
            clk_prev  <= clk_s;
        end
    end

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next;
    end

    // frame shifter (bit 0 is the bit on the wire) plus the shared inhibit/timeout counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift   <= '0;
            bit_cnt <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (txStart) begin
                    shift <= {1'b1, ~^txData, txData, 1'b0};
                    cnt   <= '0;
                end
                INHIBIT: cnt <= cnt + 1'b1;
                RTS: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                end
                SEND: begin
                    cnt <= cnt + 1'b1;
                    if (fall) begin
                        shift   <= {1'b1, shift[10:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                ACK, WAIT_IDLE: cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // next state and outputs; timeout overrides any bit position
    always_comb begin
        next      = state;
        txBusy    = state != IDLE;
        txDone    = 1'b0;
        txError   = state == ERROR;
        ps2ClkOe  = state == INHIBIT;
        ps2DataOe = (state == RTS || state == SEND || state == ACK) && !shift[0];
        case (state)
            IDLE:      if (txStart) next = INHIBIT;
            INHIBIT:   if (inh_done) next = RTS;
            RTS:       next = SEND;
            SEND:      next = timeout ? ERROR : (fall && bit_cnt == 4'd9) ? ACK : SEND;
            ACK:       next = timeout ? ERROR : fall ? (data_s ? ERROR : WAIT_IDLE) : ACK;
            WAIT_IDLE: begin
                if (timeout) next = ERROR;
                else if (clk_s && data_s) begin
                    next   = IDLE;
                    txDone = 1'b1;
                end
            end
            ERROR:     next = IDLE;
            default:   next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized device-model bench for ps2_host_tx against a frame-level reference
module tb_ps2_host_tx;
    localparam int INH = 40;
    localparam int TO  = 1000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] txData = '0;
    logic txStart = 1'b0;
    logic txBusy, txDone, txError, ps2ClkOe, ps2DataOe;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic clk_line, data_line;
    int compared = 0, mismatched = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0, run = 0, last_inh = 0;

    assign clk_line  = dev_clk & ~ps2ClkOe;
    assign data_line = dev_data & ~ps2DataOe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .txData(txData), .txStart(txStart),
        .txBusy(txBusy), .txDone(txDone), .txError(txError),
        .ps2ClkIn(clk_line), .ps2DataIn(data_line),
        .ps2ClkOe(ps2ClkOe), .ps2DataOe(ps2DataOe)
    );

    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // pulse counters and length of the most recent clock-inhibit window
    always @(negedge clock) begin
        if (txDone) done_cnt++;
        if (txError) err_cnt++;
        if (txDone && txError) both_cnt++;
        if (ps2ClkOe) run++;
        else if (run > 0) begin
            last_inh = run;
            run = 0;
        end
    end

    // expected wire bits after the start bit: data LSB first, odd parity, stop
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, 1'((ones % 2) == 0), d};
    endfunction

    // PS/2 device: waits for request-to-send, clocks the frame, samples on rising edges, drives ack
    task automatic device(input int half, input logic ack, input int edges,
                          output logic [9:0] got, output logic sb, output logic seen);
        int t = 0;
        got = '1;
        sb = 1'b1;
        seen = 1'b0;
        while (!(clk_line && !data_line) && t < INH + 200) begin
            @(negedge clock);
            t++;
        end
        if (!(clk_line && !data_line)) return;
        seen = 1'b1;
        repeat (half) @(negedge clock);
        for (int i = 0; i < edges; i++) begin
            if (i == 10) begin
                dev_data = ack;
                repeat (2) @(negedge clock);
            end
            if (i == 0) sb = data_line;
            dev_clk = 1'b0;
            repeat (half) @(negedge clock);
            dev_clk = 1'b1;
            if (i < 10) got[i] = data_line;
            repeat (half) @(negedge clock);
        end
        dev_data = 1'b1;
    endtask

    // waits for a done/error pulse; kind = {done, error}
    task automatic wait_pulse(input int bound, output int kind, output int waited,
                              output logic [1:0] oe_at, output logic [1:0] oe_after, output logic busy_after);
        waited = 0;
        while (!(txDone || txError) && waited < bound) begin
            @(negedge clock);
            waited++;
        end
        kind = int'({txDone, txError});
        oe_at = {ps2ClkOe, ps2DataOe};
        @(negedge clock);
        oe_after = {ps2ClkOe, ps2DataOe};
        busy_after = txBusy;
    endtask

    task automatic xfer(input string tag, input logic [7:0] d, input int half, input logic ack, input logic rogue);
        logic [9:0] got;
        logic sb, seen, busy_after;
        logic [1:0] oe_at, oe_after;
        int kind, waited, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clock);
        txData = d;
        txStart = 1'b1;
        @(negedge clock);
        txStart = 1'b0;
        txData = 8'($urandom);
        check({tag, " busy"}, 32'(txBusy), 1);
        fork
            device(half, ack, 11, got, sb, seen);
            wait_pulse(INH + TO + 200, kind, waited, oe_at, oe_after, busy_after);
            if (rogue) begin
                repeat (INH + 30) @(negedge clock);
                txData = 8'h55;
                txStart = 1'b1;
                @(negedge clock);
                txStart = 1'b0;
            end
        join
        repeat (5) @(negedge clock);
        check({tag, " rts seen"}, 32'(seen), 1);
        check({tag, " start bit"}, 32'(sb), 0);
        check({tag, " frame"}, 32'(got), 32'(model_frame(d)));
        check({tag, " inhibit len"}, last_inh, INH);
        check({tag, " pulse kind"}, kind, ack ? 1 : 2);
        check({tag, " lines after"}, 32'(oe_after), 0);
        check({tag, " busy after"}, 32'(busy_after), 0);
        check({tag, " done count"}, done_cnt - d0, ack ? 0 : 1);
        check({tag, " error count"}, err_cnt - e0, ack ? 1 : 0);
    endtask

    initial begin
        logic [9:0] got;
        logic sb, seen, busy_after;
        logic [1:0] oe_at, oe_after;
        int kind, waited, t, d0, busy_seen;

        repeat (3) @(negedge clock);
        check("reset clkoe", 32'(ps2ClkOe), 0);
        check("reset dataoe", 32'(ps2DataOe), 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle busy", 32'(txBusy), 0);
        check("idle done", 32'(txDone), 0);
        check("idle error", 32'(txError), 0);

        xfer("t1 ED", 8'hED, 20, 1'b0, 1'b0);

        // 0x07 then a start on the done cycle (ignored) and the cycle after (accepted)
        d0 = done_cnt;
        @(negedge clock);
        txData = 8'h07;
        txStart = 1'b1;
        @(negedge clock);
        txStart = 1'b0;
        fork
            device(12, 1'b0, 11, got, sb, seen);
            begin
                t = 0;
                while (!txDone && t < INH + TO + 200) begin
                    @(negedge clock);
                    t++;
                end
                txStart = 1'b1;
                txData = 8'h3C;
                @(negedge clock);
                check("t2 start on done cycle ignored", 32'(txBusy), 0);
                @(negedge clock);
                txStart = 1'b0;
                check("t2 start after done accepted", 32'(txBusy), 1);
            end
        join
        check("t2 frame", 32'(got), 32'(model_frame(8'h07)));
        check("t2 parity cell", 32'(got[8]), 0);
        fork
            device(12, 1'b0, 11, got, sb, seen);
            wait_pulse(INH + TO + 200, kind, waited, oe_at, oe_after, busy_after);
        join
        check("t2b frame", 32'(got), 32'(model_frame(8'h3C)));
        check("t2b kind", kind, 2);
        check("t2 done count", done_cnt - d0, 2);

        xfer("t3 noack", 8'h00, 15, 1'b1, 1'b0);

        // no device clocking: timeout measured from the RTS cycle
        @(negedge clock);
        txData = 8'h12;
        txStart = 1'b1;
        @(negedge clock);
        txStart = 1'b0;
        t = 0;
        while (ps2ClkOe && t < INH + 50) begin
            @(negedge clock);
            t++;
        end
        check("t4 rts data", 32'(ps2DataOe), 1);
        check("t4 rts clk", 32'(ps2ClkOe), 0);
        wait_pulse(TO + 100, kind, waited, oe_at, oe_after, busy_after);
        check("t4 kind", kind, 1);
        check("t4 latency", waited, TO + 1);
        check("t4 lines at error", 32'(oe_at), 0);
        check("t4 lines after", 32'(oe_after), 0);
        check("t4 busy after", 32'(busy_after), 0);

        xfer("t5 F4", 8'hF4, 14, 1'b0, 1'b1);
        busy_seen = 0;
        repeat (100) begin
            @(negedge clock);
            busy_seen += int'(txBusy);
        end
        check("t5 not queued", busy_seen, 0);

        // async reset after the 4th falling edge
        @(negedge clock);
        txData = 8'hAA;
        txStart = 1'b1;
        @(negedge clock);
        txStart = 1'b0;
        device(15, 1'b0, 4, got, sb, seen);
        check("t6 first bits", 32'(got[3:0]), 32'h0A);
        check("t6 busy before reset", 32'(txBusy), 1);
        #2 reset = 1'b1;
        #1;
        check("t6 reset clkoe", 32'(ps2ClkOe), 0);
        check("t6 reset dataoe", 32'(ps2DataOe), 0);
        check("t6 reset busy", 32'(txBusy), 0);
        @(negedge clock);
        reset = 1'b0;
        xfer("t6 AA again", 8'hAA, 15, 1'b0, 1'b0);

        // async reset in the middle of the inhibit window
        @(negedge clock);
        txData = 8'h3C;
        txStart = 1'b1;
        @(negedge clock);
        txStart = 1'b0;
        repeat (10) @(negedge clock);
        check("inh clkoe", 32'(ps2ClkOe), 1);
        #2 reset = 1'b1;
        #1;
        check("inh reset clkoe", 32'(ps2ClkOe), 0);
        @(negedge clock);
        reset = 1'b0;

        for (int k = 0; k < 6; k++)
            xfer("rnd", 8'($urandom), int'($urandom_range(8, 20)), 1'($urandom_range(0, 3) == 0), 1'b0);

        check("never both pulses", both_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
